// File: rtl/spmv_pkg.sv
// Shared types for the SpMV compute lane.
// Pipeline slots are sized for the widest supported lane.
package spmv_pkg;
   localparam int DIM_W_DEF   = 10;
   localparam int DATA_W_DEF  = 32;
   localparam int SLOT_DATA_W = 64;
   localparam int SLOT_ROW_W  = 32;

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      FLUSH,
      DONE
   } lane_state_e;

   typedef struct packed {
      logic                   valid;
      logic [SLOT_ROW_W-1:0]  row;
      logic [SLOT_DATA_W-1:0] prod;
   } pipe_slot_t;
endpackage

// File: rtl/spmv_sync_fifo.sv
// Synchronous FIFO with combinational head and sticky last-read value.
// A pop on a full FIFO frees space for a same-cycle push.
module spmv_sync_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              empty
);
   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wptr;
   logic [AW-1:0]     rptr;
   logic [AW:0]       cnt;
   logic [DATA_W-1:0] last_q;
   logic              full;
   logic              do_push;
   logic              do_pop;

   assign full     = (cnt == (AW+1)'(DEPTH));
   assign empty    = (cnt == '0);
   assign wr_ready = !full;
   assign do_pop   = rd_en && !empty;
   assign do_push  = wr_valid && (!full || do_pop);
   assign rd_data  = empty ? last_q : mem[rptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         wptr   <= '0;
         rptr   <= '0;
         cnt    <= '0;
         last_q <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop) begin
            rptr   <= rptr + 1'b1;
            last_q <= mem[rptr];
         end
         if (do_push && !do_pop) cnt <= cnt + 1'b1;
         else if (do_pop && !do_push) cnt <= cnt - 1'b1;
      end
   end
endmodule

// File: rtl/spmv_lane_pipe.sv
// SpMV lane: pipelined multiply, per-row accumulate, result handoff.
// Row results leave through a one-entry valid/ready register.
module spmv_lane_pipe
   import spmv_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int DIM_W       = DIM_W_DEF,
   parameter int MUL_LAT     = 4,
   parameter int RL_DEPTH    = 64,
   parameter bit SIGNED_MODE = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              spmv_init,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_mval,
   input  logic [DATA_W-1:0] in_vval,
   input  logic [DIM_W-1:0]  in_row,
   input  logic              done_in,
   input  logic              rl_wr_valid,
   input  logic [DATA_W-1:0] rl_wr_data,
   output logic              rl_wr_ready,
   input  logic              rl_rd_en,
   output logic [DATA_W-1:0] rl_rd_data,
   output logic              rl_empty,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DIM_W-1:0]  res_row,
   output logic [DATA_W-1:0] res_data,
   output logic              lane_done,
   output logic [31:0]       nnz_cnt,
   output logic [31:0]       row_cnt
);
   logic                clr;
   logic                stall;
   logic                accept;
   logic [2*DATA_W-1:0] a_x;
   logic [2*DATA_W-1:0] b_x;
   logic [2*DATA_W-1:0] prod_full;
   logic [DATA_W-1:0]   prod;
   pipe_slot_t          pipe [MUL_LAT];
   pipe_slot_t          tail;
   logic [DATA_W-1:0]   t_prod;
   logic [DIM_W-1:0]    t_row;
   logic                pipe_empty;
   logic                unused_bits;

   lane_state_e         state, state_n;
   logic [DATA_W-1:0]   acc, acc_n;
   logic [DIM_W-1:0]    open_row, open_row_n;
   logic                open_vld, open_vld_n;
   logic                res_valid_n;
   logic [DIM_W-1:0]    res_row_n;
   logic [DATA_W-1:0]   res_data_n;

   assign clr       = !rst_n || spmv_init;
   assign stall     = res_valid && !res_ready;
   assign in_ready  = !stall && (state == IDLE || state == ACC);
   assign accept    = in_valid && in_ready;
   assign lane_done = (state == DONE) && !res_valid;

   // Low half of the product is the same for either sign; extend anyway.
   if (SIGNED_MODE) begin : g_sx
      assign a_x = {{DATA_W{in_mval[DATA_W-1]}}, in_mval};
      assign b_x = {{DATA_W{in_vval[DATA_W-1]}}, in_vval};
   end else begin : g_zx
      assign a_x = {{DATA_W{1'b0}}, in_mval};
      assign b_x = {{DATA_W{1'b0}}, in_vval};
   end
   assign prod_full = a_x * b_x;
   assign prod      = prod_full[DATA_W-1:0];

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < MUL_LAT; i++) pipe[i] <= '0;
      end else if (!stall) begin
         pipe[0].valid <= accept;
         pipe[0].row   <= SLOT_ROW_W'(in_row);
         pipe[0].prod  <= SLOT_DATA_W'(prod);
         for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign tail        = pipe[MUL_LAT-1];
   assign t_prod      = tail.prod[DATA_W-1:0];
   assign t_row       = tail.row[DIM_W-1:0];
   assign unused_bits = ^{tail.prod, tail.row};

   always_comb begin
      pipe_empty = 1'b1;
      for (int i = 0; i < MUL_LAT; i++)
         if (pipe[i].valid) pipe_empty = 1'b0;
   end

   always_comb begin
      state_n     = state;
      acc_n       = acc;
      open_row_n  = open_row;
      open_vld_n  = open_vld;
      res_valid_n = res_valid;
      res_row_n   = res_row;
      res_data_n  = res_data;
      if (res_valid && res_ready) res_valid_n = 1'b0;
      if (!stall && state != DONE && tail.valid) begin
         if (!open_vld) begin
            acc_n      = t_prod;
            open_row_n = t_row;
            open_vld_n = 1'b1;
         end else if (t_row == open_row) begin
            acc_n = acc + t_prod;
         end else begin
            res_valid_n = 1'b1;
            res_row_n   = open_row;
            res_data_n  = acc;
            acc_n       = t_prod;
            open_row_n  = t_row;
         end
      end
      unique case (state)
         IDLE: begin
            if (done_in) state_n = FLUSH;
            else if (!stall && tail.valid) state_n = ACC;
         end
         ACC: if (done_in) state_n = FLUSH;
         FLUSH: begin
            if (!stall && pipe_empty) begin
               if (open_vld) begin
                  res_valid_n = 1'b1;
                  res_row_n   = open_row;
                  res_data_n  = acc;
               end
               open_vld_n = 1'b0;
               state_n    = DONE;
            end
         end
         DONE: state_n = DONE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state     <= IDLE;
         acc       <= '0;
         open_row  <= '0;
         open_vld  <= 1'b0;
         res_valid <= 1'b0;
         res_row   <= '0;
         res_data  <= '0;
         nnz_cnt   <= '0;
         row_cnt   <= '0;
      end else begin
         state     <= state_n;
         acc       <= acc_n;
         open_row  <= open_row_n;
         open_vld  <= open_vld_n;
         res_valid <= res_valid_n;
         res_row   <= res_row_n;
         res_data  <= res_data_n;
         if (accept) nnz_cnt <= nnz_cnt + 32'd1;
         if (res_valid && res_ready) row_cnt <= row_cnt + 32'd1;
      end
   end

   spmv_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (RL_DEPTH)
   ) u_rl_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (spmv_init),
      .wr_valid (rl_wr_valid),
      .wr_data  (rl_wr_data),
      .wr_ready (rl_wr_ready),
      .rd_en    (rl_rd_en),
      .rd_data  (rl_rd_data),
      .empty    (rl_empty)
   );
endmodule

// File: doc/spmv_lane_pipe.md
Name: spmv_lane_pipe

Overview:
- Single parametrised SpMV compute lane: multiplies streamed (matrix value, vector value, row id) elements and accumulates per row.
- Emits one (row id, sum) result per completed row over a valid/ready output.
- Includes a row-length FIFO feeding the CISR decoder.
- Sits between the fetch arbiter/BVB and the output-vector writer; NUM lanes are instantiated side by side.

Parameters:
- DATA_W, 32, width of matrix values, vector values, products and sums.
- DIM_W, 10, width of row ids.
- MUL_LAT, 4, multiplier pipeline depth in cycles (legal range 1..8).
- RL_DEPTH, 64, row-length FIFO depth (power of two).
- SIGNED_MODE, 0, 1 = signed multiply, 0 = unsigned; products always truncated to DATA_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- spmv_init  in  1  synchronous soft clear, same effect as reset
- in_valid  in  1  element valid
- in_ready  out  1  lane can accept an element
- in_mval  in  DATA_W  matrix value
- in_vval  in  DATA_W  vector value
- in_row  in  DIM_W  row id of element
- done_in  in  1  single-cycle pulse: no more elements will arrive
- rl_wr_valid  in  1  push row length
- rl_wr_data  in  DATA_W  row length
- rl_wr_ready  out  1  FIFO not full
- rl_rd_en  in  1  pop row length
- rl_rd_data  out  DATA_W  head of FIFO
- rl_empty  out  1  FIFO empty
- res_valid  out  1  row result valid
- res_ready  in  1  consumer accepts result
- res_row  out  DIM_W  row id of result
- res_data  out  DATA_W  accumulated sum
- lane_done  out  1  all results delivered
- nnz_cnt  out  32  elements accepted since clear
- row_cnt  out  32  results handed off since clear

Behaviour:
- Reset/clear (rst_n=0 or spmv_init=1 at a clk edge):
  - All outputs go to 0 except in_ready=1 and rl_wr_ready=1 from the next cycle.
  - FIFO is emptied (rl_empty=1) and the pipeline is invalidated.
  - The FSM enters IDLE. Clear mid-operation discards all in-flight data; no partial result is emitted.
- Stall:
  - stall = res_valid && !res_ready.
  - While stalled, every pipeline stage, the accumulator and the FSM hold.
  - in_ready = !stall && state is IDLE or ACC.
- Accept: a handshake occurs when in_valid && in_ready. nnz_cnt increments by 1 at that edge.
- Pipeline:
  - Stage 1 registers the product; stages 2..MUL_LAT shift it along with the row id and a valid bit.
  - An element accepted at edge t is at the tail stage during cycle t+MUL_LAT-1 and is consumed by the accumulator at edge t+MUL_LAT (when not stalled).
  - Invalid slots (bubbles) travel as valid=0 and are ignored.
- Arithmetic:
  - Product is the low DATA_W bits of mval*vval, signed or unsigned per SIGNED_MODE.
  - Sum is modulo 2^DATA_W; there is no saturation.
- FSM states:
  - IDLE: no open row. A valid tail loads acc=product, open_row=row, and moves to ACC.
  - ACC:
    - Tail valid with same row: acc += product.
    - Tail valid with a different row: register res_row=open_row, res_data=acc, res_valid=1; acc=product; open_row=new row.
  - FLUSH:
    - Entered on done_in, from IDLE or ACC; in_ready=0.
    - Tail elements are processed exactly as in ACC.
    - When the pipeline is empty: if a row is open, emit it once.
    - Then go to DONE.
  - DONE: lane_done=1 once res_valid is 0. Held until clear.
- Simultaneous events:
  - done_in in the same cycle as an accepted element: the element is accepted, then FLUSH is entered.
  - done_in while already in FLUSH or DONE is ignored.
  - A result is accepted (res_valid && res_ready) in the same cycle a new one is produced: the new one is registered, and res_valid stays 1.
- res_valid, res_row and res_data stay stable until the handshake. row_cnt increments per handshake.
- Row-length FIFO:
  - rl_rd_data shows the head combinationally.
  - Push when full is dropped. Pop when empty is ignored and rl_rd_data holds its last value.
  - Push and pop in the same cycle when full is allowed; the pop frees space, so the push succeeds.
  - Pointers wrap at RL_DEPTH.

Decomposition:
- Shared package spmv_pkg: DIM_W default, the lane_state_e enum {IDLE, ACC, FLUSH, DONE}, and a pipe_slot_t struct {valid, row, prod}.
- One sub-module, spmv_sync_fifo (DATA_W/DEPTH parameters), used for the row-length FIFO.

Test Plan:
- Basic row sums (MUL_LAT=4, res_ready=1): feed (2,3,r0),(4,5,r0),(1,7,r1), then done_in → results (r0,26) then (r1,7); lane_done=1; nnz_cnt=3; row_cnt=2.
- Backpressure: as above with res_ready=0 for 10 cycles after the first res_valid → in_ready=0 and res_data=26 held stable; resumes with no loss; (r1,7) follows.
- Bubbles and wrap: alternate in_valid with 0xFFFFFFFF*2 on r5, twice → (r5,0xFFFFFFFC); bubbles neither add nor emit.
- Signed mode (SIGNED_MODE=1): (-3,4,r2),(5,2,r2) → (r2,-2).
- FIFO: push 64 lengths → rl_wr_ready=0; push+pop together when full → count unchanged and FIFO order preserved; pop when empty → rl_rd_data holds its last value.
- Clear mid-stream: spmv_init with 3 elements in flight → no results; nnz_cnt=0; rl_empty=1; next row sums correctly.
